// File: rtl/switch_arbiter.sv
// 5-port mesh NoC switch allocator: wormhole-locked round-robin per output.
// Define ARB_FIXED_PRIO_EN for fixed L>N>E>S>W priority on free outputs.
module switch_arbiter #(
  parameter int NPORTS = 5,
  parameter int CODE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] request_L,
  input  logic [CODE_W-1:0] request_N,
  input  logic [CODE_W-1:0] request_E,
  input  logic [CODE_W-1:0] request_S,
  input  logic [CODE_W-1:0] request_W,
  output logic [CODE_W-1:0] select_L,
  output logic [CODE_W-1:0] select_N,
  output logic [CODE_W-1:0] select_E,
  output logic [CODE_W-1:0] select_S,
  output logic [CODE_W-1:0] select_W,
  output logic              ack_L,
  output logic              ack_N,
  output logic              ack_E,
  output logic              ack_S,
  output logic              ack_W
);

  logic [CODE_W-1:0] req   [NPORTS];
  logic [CODE_W-1:0] sel_q [NPORTS];
  logic [CODE_W-1:0] sel_d [NPORTS];
  logic [NPORTS-1:0] ack_q;
  logic [NPORTS-1:0] ack_d;
  logic [NPORTS-1:0] rq    [NPORTS];
  logic [NPORTS-1:0] own   [NPORTS];
  logic [NPORTS-1:0] hold;

  assign req[0] = request_L;
  assign req[1] = request_N;
  assign req[2] = request_E;
  assign req[3] = request_S;
  assign req[4] = request_W;

  // rq[o][i]: input i validly requests output o (U-turns and codes 6/7 never match)
  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) begin
        rq[o][i]  = (req[i] == CODE_W'(o + 1)) && (i != o);
        own[o][i] = (sel_q[o] == CODE_W'(i + 1));
      end
      hold[o] = |(rq[o] & own[o]);
    end
  end

`ifdef ARB_FIXED_PRIO_EN

  function automatic logic [CODE_W-1:0] pick(
    input logic [NPORTS-1:0] m
  );
    logic [CODE_W-1:0] w;
    w = '0;
    for (int i = NPORTS - 1; i >= 0; i--)
      if (m[i]) w = CODE_W'(i + 1);
    return w;
  endfunction

  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      sel_d[o] = sel_q[o];
      if (!hold[o])
        sel_d[o] = pick(rq[o]);
    end
  end

`else

  logic [CODE_W-1:0] ptr_q [NPORTS];
  logic [CODE_W-1:0] ptr_d [NPORTS];

  // Scan from farthest to nearest so the input right after p wins last.
  function automatic logic [CODE_W-1:0] pick(
    input logic [NPORTS-1:0] m,
    input logic [CODE_W-1:0] p
  );
    logic [CODE_W-1:0] w;
    int t;
    w = '0;
    for (int k = NPORTS; k >= 1; k--) begin
      t = int'(p) + k;
      if (t >= NPORTS) t = t - NPORTS;
      if (m[t]) w = CODE_W'(t + 1);
    end
    return w;
  endfunction

  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      sel_d[o] = sel_q[o];
      ptr_d[o] = ptr_q[o];
      if (!hold[o]) begin
        sel_d[o] = pick(rq[o], ptr_q[o]);
        if (sel_d[o] != '0)
          ptr_d[o] = sel_d[o] - CODE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int o = 0; o < NPORTS; o++) begin
      if (rst) ptr_q[o] <= CODE_W'(NPORTS - 1);
      else     ptr_q[o] <= ptr_d[o];
    end
  end

`endif

  always_comb begin
    ack_d = '0;
    for (int o = 0; o < NPORTS; o++)
      for (int i = 0; i < NPORTS; i++)
        if (sel_d[o] == CODE_W'(i + 1)) ack_d[i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ack_q <= '0;
    else     ack_q <= ack_d;
    for (int o = 0; o < NPORTS; o++) begin
      if (rst) sel_q[o] <= '0;
      else     sel_q[o] <= sel_d[o];
    end
  end

  assign select_L = sel_q[0];
  assign select_N = sel_q[1];
  assign select_E = sel_q[2];
  assign select_S = sel_q[3];
  assign select_W = sel_q[4];
  assign ack_L    = ack_q[0];
  assign ack_N    = ack_q[1];
  assign ack_E    = ack_q[2];
  assign ack_S    = ack_q[3];
  assign ack_W    = ack_q[4];

endmodule

// File: tb/tb_switch_arbiter.sv
// Testbench for switch_arbiter: directed scenarios plus randomized traffic
// checked against a per-output owner/pointer reference model.
module tb_switch_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] request_L = '0, request_N = '0, request_E = '0;
  logic [2:0] request_S = '0, request_W = '0;
  logic [2:0] select_L, select_N, select_E, select_S, select_W;
  logic       ack_L, ack_N, ack_E, ack_S, ack_W;

  int vectors = 0;
  int miscompares = 0;

  int m_owner [5];
  int m_ptr   [5];
  int m_req   [5];

  always #5 clk = ~clk;

  switch_arbiter dut (
    .clk(clk), .rst(rst),
    .request_L(request_L), .request_N(request_N), .request_E(request_E),
    .request_S(request_S), .request_W(request_W),
    .select_L(select_L), .select_N(select_N), .select_E(select_E),
    .select_S(select_S), .select_W(select_W),
    .ack_L(ack_L), .ack_N(ack_N), .ack_E(ack_E),
    .ack_S(ack_S), .ack_W(ack_W)
  );

  wire [19:0] obs = {select_L, select_N, select_E, select_S, select_W,
                     ack_L, ack_N, ack_E, ack_S, ack_W};

  function automatic logic [19:0] exp_vec();
    logic [19:0] v;
    logic [4:0]  a;
    a = '0;
    for (int o = 0; o < 5; o++)
      if (m_owner[o] != 0) a[5 - m_owner[o]] = 1'b1;
    v = {m_owner[0][2:0], m_owner[1][2:0], m_owner[2][2:0],
         m_owner[3][2:0], m_owner[4][2:0], a};
    return v;
  endfunction

  // Output o (code o+1): keep a still-requesting owner, otherwise the first
  // valid requester in priority order wins.
  task automatic model_step(input logic r);
    int cand;
    bit done;
    for (int o = 0; o < 5; o++) begin
      if (r) begin
        m_owner[o] = 0;
        m_ptr[o] = 5;
      end else if (!(m_owner[o] != 0 && m_req[m_owner[o] - 1] == o + 1)) begin
        m_owner[o] = 0;
        done = 0;
        for (int k = 1; k <= 5; k++) begin
`ifdef ARB_FIXED_PRIO_EN
          cand = k;
`else
          cand = ((m_ptr[o] - 1 + k) % 5) + 1;
`endif
          if (!done && m_req[cand - 1] == o + 1 && cand != o + 1) begin
            m_owner[o] = cand;
            m_ptr[o] = cand;
            done = 1;
          end
        end
      end
    end
  endtask

  task automatic apply(input logic [2:0] l, n, e, s, w, input logic r);
    request_L = l; request_N = n; request_E = e;
    request_S = s; request_W = w; rst = r;
    m_req[0] = int'(l); m_req[1] = int'(n); m_req[2] = int'(e);
    m_req[3] = int'(s); m_req[4] = int'(w);
    @(posedge clk);
    #1;
    model_step(r);
  endtask

  task automatic test_reset();
    apply(3'($urandom), 3'($urandom), 3'($urandom),
          3'($urandom), 3'($urandom), 1'b1);
    vectors++;
    if (obs !== 20'h0) begin
      $display("FAIL reset obs=%h exp=%h", obs, 20'h0);
      miscompares++;
    end
  endtask

  task automatic test_single();
    apply(0, 0, 0, 0, 0, 1'b1);
    apply(0, 0, 1, 0, 0, 1'b0);
    vectors++;
    if (obs !== exp_vec() || select_L !== 3'd3 || ack_E !== 1'b1) begin
      $display("FAIL single_grant obs=%h exp=%h", obs, exp_vec());
      miscompares++;
    end
    apply(0, 0, 0, 0, 0, 1'b0);
    vectors++;
    if (obs !== exp_vec() || select_L !== 3'd0 || ack_E !== 1'b0) begin
      $display("FAIL single_release obs=%h exp=%h", obs, exp_vec());
      miscompares++;
    end
  endtask

  task automatic test_contention();
    apply(0, 0, 0, 0, 0, 1'b1);
    apply(0, 1, 0, 1, 0, 1'b0);
    vectors++;
    if (obs !== exp_vec() || select_L !== 3'd2 || ack_N !== 1'b1 ||
        ack_S !== 1'b0) begin
      $display("FAIL contend_first obs=%h exp=%h", obs, exp_vec());
      miscompares++;
    end
    for (int c = 0; c < 3; c++) begin
      apply(0, 1, 0, 1, 0, 1'b0);
      vectors++;
      if (obs !== exp_vec() || select_L !== 3'd2) begin
        $display("FAIL contend_lock obs=%h exp=%h", obs, exp_vec());
        miscompares++;
      end
    end
    apply(0, 0, 0, 1, 0, 1'b0);
    vectors++;
    if (obs !== exp_vec() || select_L !== 3'd4 || ack_S !== 1'b1) begin
      $display("FAIL contend_handoff obs=%h exp=%h", obs, exp_vec());
      miscompares++;
    end
    apply(0, 1, 0, 1, 0, 1'b0);
    vectors++;
    if (obs !== exp_vec() || select_L !== 3'd4 || ack_N !== 1'b0) begin
      $display("FAIL contend_wait obs=%h exp=%h", obs, exp_vec());
      miscompares++;
    end
    apply(0, 1, 0, 0, 0, 1'b0);
    vectors++;
    if (obs !== exp_vec() || select_L !== 3'd2 || ack_N !== 1'b1) begin
      $display("FAIL contend_return obs=%h exp=%h", obs, exp_vec());
      miscompares++;
    end
  endtask

  task automatic test_parallel();
    apply(0, 0, 0, 0, 0, 1'b1);
    apply(2, 3, 4, 5, 1, 1'b0);
    vectors++;
    if (obs !== exp_vec() ||
        obs !== {3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 5'b11111}) begin
      $display("FAIL parallel obs=%h exp=%h", obs, exp_vec());
      miscompares++;
    end
  endtask

  task automatic test_illegal();
    apply(0, 0, 0, 0, 0, 1'b1);
    apply(0, 6, 0, 7, 5, 1'b0);
    vectors++;
    if (obs !== exp_vec() || obs !== 20'h0) begin
      $display("FAIL illegal obs=%h exp=%h", obs, 20'h0);
      miscompares++;
    end
    apply(1, 2, 3, 4, 5, 1'b0);
    vectors++;
    if (obs !== exp_vec() || obs !== 20'h0) begin
      $display("FAIL uturn_all obs=%h exp=%h", obs, 20'h0);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    apply(0, 0, 0, 0, 0, 1'b1);
    apply(0, 0, 1, 0, 0, 1'b0);
    apply(0, 0, 1, 0, 0, 1'b1);
    vectors++;
    if (obs !== exp_vec() || select_L !== 3'd0 || ack_E !== 1'b0) begin
      $display("FAIL reset_mid obs=%h exp=%h", obs, exp_vec());
      miscompares++;
    end
    apply(0, 0, 1, 0, 0, 1'b0);
    vectors++;
    if (obs !== exp_vec() || select_L !== 3'd3 || ack_E !== 1'b1) begin
      $display("FAIL reset_regrant obs=%h exp=%h", obs, exp_vec());
      miscompares++;
    end
  endtask

  task automatic test_random();
    logic [2:0] r [5];
    logic       rr;
    apply(0, 0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 5; i++) r[i] = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 5; i++)
        if ($urandom_range(3) == 0) r[i] = 3'($urandom);
      rr = ($urandom_range(49) == 0);
      apply(r[0], r[1], r[2], r[3], r[4], rr);
      vectors++;
      if (obs !== exp_vec()) begin
        $display("FAIL random c=%0d obs=%h exp=%h", c, obs, exp_vec());
        miscompares++;
      end
    end
  endtask

  initial begin
    for (int o = 0; o < 5; o++) begin
      m_owner[o] = 0;
      m_ptr[o] = 5;
      m_req[o] = 0;
    end
    test_reset();
    test_single();
    test_contention();
    test_parallel();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
